// File: rtl/conv_line_buffer.sv
// Raster line buffer for the 3x3 convolution stage: emits rows r-2, r-1, r per column
// and replays a 9-coefficient kernel as three column triples in a 4-cycle load.
module conv_line_buffer #(
   parameter int IMG_WIDTH = 640,
   parameter int NB_PIXEL  = 8,
   parameter int NB_ADDR   = $clog2(IMG_WIDTH)
) (
   input  logic                       clk,
   input  logic                       i_rst,
   input  logic                       i_valid,
   input  logic                       i_sof,
   input  logic signed [NB_PIXEL-1:0] i_pixel,
   input  logic                       i_knl_valid,
   input  logic signed [NB_PIXEL-1:0] i_knl_coeff,
   output logic                       o_pix_ready,
   output logic                       o_knl_ready,
   output logic signed [NB_PIXEL-1:0] o_data1,
   output logic signed [NB_PIXEL-1:0] o_data2,
   output logic signed [NB_PIXEL-1:0] o_data3,
   output logic                       o_en_conv,
   output logic                       o_load_knl,
   output logic                       o_win_valid
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_KCOLLECT,
      ST_KSEND
   } state_t;

   localparam logic [NB_ADDR-1:0] COL_LAST = NB_ADDR'(IMG_WIDTH - 1);

   state_t                     state;
   state_t                     state_next;
   logic [NB_ADDR-1:0]         col;
   logic [NB_ADDR-1:0]         col_cur;
   logic [NB_ADDR-1:0]         col_next;
   logic [1:0]                 row;
   logic [1:0]                 row_cur;
   logic [1:0]                 row_next;
   logic [3:0]                 knl_idx;
   logic [1:0]                 send_cnt;
   logic [3:0]                 send_col;
   logic                       pix_acc;
   logic                       knl_acc;
   logic                       knl_last;
   logic signed [NB_PIXEL-1:0] lb0_rd;
   logic signed [NB_PIXEL-1:0] lb1_rd;

   logic signed [NB_PIXEL-1:0] lb0 [IMG_WIDTH];
   logic signed [NB_PIXEL-1:0] lb1 [IMG_WIDTH];
   logic signed [NB_PIXEL-1:0] knl [9];

   always_comb begin
      o_pix_ready = (state == ST_RUN);
      o_knl_ready = (state != ST_KSEND);
   end

   assign pix_acc  = i_valid && o_pix_ready;
   assign knl_acc  = i_knl_valid && o_knl_ready;
   assign knl_last = knl_acc && (state == ST_KCOLLECT) && (knl_idx == 4'd8);
   assign send_col = {2'b00, send_cnt} + 4'd1;

   // i_sof re-arms the raster position for the pixel that carries it
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      col_cur  = i_sof ? '0 : col;
      row_cur  = i_sof ? 2'd0 : row;
      col_next = col_cur + NB_ADDR'(1);
      row_next = row_cur;
      if (col_cur == COL_LAST) begin
         col_next = '0;
         if (row_cur != 2'd2) begin
            row_next = row_cur + 2'd1;
         end
      end
   end

   assign lb0_rd = lb0[col_cur];
   assign lb1_rd = lb1[col_cur];

   always_comb begin
      state_next = state;
      case (state)
         ST_RUN:      if (knl_acc) state_next = ST_KCOLLECT;
         ST_KCOLLECT: if (knl_last) state_next = ST_KSEND;
         ST_KSEND:    if (send_cnt == 2'd3) state_next = ST_RUN;
         default:     state_next = ST_RUN;
      endcase
   end

   // NOTE: state and output registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state       <= ST_RUN;
         col         <= '0;
         row         <= '0;
         knl_idx     <= '0;
         send_cnt    <= '0;
         o_data1     <= '0;
         o_data2     <= '0;
         o_data3     <= '0;
         o_en_conv   <= 1'b0;
         o_win_valid <= 1'b0;
         o_load_knl  <= 1'b0;
      end else begin
         state       <= state_next;
         o_en_conv   <= 1'b0;
         o_win_valid <= 1'b0;
         o_load_knl  <= 1'b0;

         if (pix_acc) begin
            col         <= col_next;
            row         <= row_next;
            o_data1     <= lb1_rd;
            o_data2     <= lb0_rd;
            o_data3     <= i_pixel;
            o_en_conv   <= (row_cur == 2'd2);
            o_win_valid <= (row_cur == 2'd2) && (col_cur >= NB_ADDR'(2));
         end

         if (knl_acc) begin
            knl_idx <= knl_last ? 4'd0 : knl_idx + 4'd1;
         end

         // Column 0 goes out on the edge that stores k9; k1, k4, k7 are already held
         if (knl_last) begin
            send_cnt   <= '0;
            o_load_knl <= 1'b1;
            o_data1    <= knl[0];
            o_data2    <= knl[3];
            o_data3    <= knl[6];
         end

         if (state == ST_KSEND) begin
            send_cnt <= send_cnt + 2'd1;
            if (send_cnt != 2'd3) begin
               o_load_knl <= 1'b1;
            end
            if (send_cnt < 2'd2) begin
               o_data1 <= knl[send_col];
               o_data2 <= knl[send_col + 4'd3];
               o_data3 <= knl[send_col + 4'd6];
            end else if (send_cnt == 2'd2) begin
               o_data1 <= '0;
               o_data2 <= '0;
               o_data3 <= '0;
            end
         end
      end
   end

   // NOTE: line and coefficient storage has no reset; every word is written before it feeds a window, so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (!i_rst && pix_acc) begin
         lb1[col_cur] <= lb0_rd;
         lb0[col_cur] <= i_pixel;
      end
      if (!i_rst && knl_acc) begin
         knl[knl_idx] <= i_knl_coeff;
      end
   end

endmodule

// File: tb/tb_conv_line_buffer.sv
// Self-checking bench for conv_line_buffer: directed vector table, hand-written
// corner sequences, then random traffic against a column-history reference model.
module tb_conv_line_buffer;

   localparam int W  = 4;
   localparam int NB = 8;

   typedef logic signed [NB-1:0] pix_t;

   typedef struct {
      bit   v;
      bit   sof;
      pix_t pix;
      bit   kv;
      pix_t kc;
      bit   pr;
      bit   kr;
      bit   en;
      bit   win;
      bit   ld;
      bit   c12;
      bit   c3;
      pix_t d1;
      pix_t d2;
      pix_t d3;
   } vec_t;

   typedef struct {
      pix_t a;
      pix_t b;
      pix_t c;
   } trip_t;

   typedef enum {M_RUN, M_COLLECT, M_SEND} mmode_t;

   logic clk = 1'b0;
   logic i_rst, i_valid, i_sof, i_knl_valid;
   pix_t i_pixel, i_knl_coeff;
   logic o_pix_ready, o_knl_ready, o_en_conv, o_load_knl, o_win_valid;
   pix_t o_data1, o_data2, o_data3;

   int n_checks = 0;
   int n_fail   = 0;

   conv_line_buffer #(.IMG_WIDTH(W), .NB_PIXEL(NB)) dut (
      .clk         (clk),
      .i_rst       (i_rst),
      .i_valid     (i_valid),
      .i_sof       (i_sof),
      .i_pixel     (i_pixel),
      .i_knl_valid (i_knl_valid),
      .i_knl_coeff (i_knl_coeff),
      .o_pix_ready (o_pix_ready),
      .o_knl_ready (o_knl_ready),
      .o_data1     (o_data1),
      .o_data2     (o_data2),
      .o_data3     (o_data3),
      .o_en_conv   (o_en_conv),
      .o_load_knl  (o_load_knl),
      .o_win_valid (o_win_valid)
   );

   always #5 clk = ~clk;

   // Reference model: each column keeps the last two pixels written to it
   mmode_t m_mode = M_RUN;
   int     m_row  = 0;
   int     m_col  = 0;
   int     m_n    = 0;
   pix_t   m_coef [9];
   pix_t   m_hist [W][$];
   trip_t  m_sendq[$];
   pix_t   e_d1 = '0, e_d2 = '0, e_d3 = '0;
   bit     e_k1 = 1'b1, e_k2 = 1'b1, e_k3 = 1'b1;
   bit     e_pr = 1'b1, e_kr = 1'b1, e_en = 1'b0, e_win = 1'b0, e_ld = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit rst, input bit v, input bit sof, input pix_t pix,
                             input bit kv, input pix_t kc);
      int c, r, n;
      trip_t t;
      e_en  = 1'b0;
      e_win = 1'b0;
      e_ld  = 1'b0;
      if (rst) begin
         m_mode = M_RUN;
         m_row  = 0;
         m_col  = 0;
         m_n    = 0;
         m_sendq.delete();
         e_d1 = '0; e_d2 = '0; e_d3 = '0;
         e_k1 = 1'b1; e_k2 = 1'b1; e_k3 = 1'b1;
      end else begin
         case (m_mode)
            M_RUN: begin
               if (v) begin
                  c = sof ? 0 : m_col;
                  r = sof ? 0 : m_row;
                  n = m_hist[c].size();
                  e_k1 = (n >= 2);
                  e_k2 = (n >= 1);
                  if (e_k1) e_d1 = m_hist[c][n-2];
                  if (e_k2) e_d2 = m_hist[c][n-1];
                  e_d3 = pix;
                  e_k3 = 1'b1;
                  m_hist[c].push_back(pix);
                  if (m_hist[c].size() > 2) void'(m_hist[c].pop_front());
                  e_en  = (r >= 2);
                  e_win = (r >= 2) && (c >= 2);
                  m_col = (c + 1) % W;
                  m_row = (c == W - 1) ? ((r + 1 > 2) ? 2 : r + 1) : r;
               end
               if (kv) begin
                  m_coef[0] = kc;
                  m_n       = 1;
                  m_mode    = M_COLLECT;
               end
            end
            M_COLLECT: begin
               if (kv) begin
                  m_coef[m_n] = kc;
                  m_n++;
                  if (m_n == 9) begin
                     for (int j = 0; j < 3; j++) begin
                        t.a = m_coef[j]; t.b = m_coef[3+j]; t.c = m_coef[6+j];
                        m_sendq.push_back(t);
                     end
                     t.a = '0; t.b = '0; t.c = '0;
                     m_sendq.push_back(t);
                     m_mode = M_SEND;
                  end
               end
            end
            default: begin
               if (m_sendq.size() == 0) m_mode = M_RUN;
            end
         endcase
         if (m_mode == M_SEND && m_sendq.size() > 0) begin
            t = m_sendq.pop_front();
            e_d1 = t.a; e_d2 = t.b; e_d3 = t.c;
            e_k1 = 1'b1; e_k2 = 1'b1; e_k3 = 1'b1;
            e_ld = 1'b1;
         end
      end
      e_pr = (m_mode == M_RUN);
      e_kr = (m_mode != M_SEND);
   endtask

   task automatic cycle(input bit rst, input bit v, input bit sof, input pix_t pix,
                        input bit kv, input pix_t kc);
      i_rst       = rst;
      i_valid     = v;
      i_sof       = sof;
      i_pixel     = pix;
      i_knl_valid = kv;
      i_knl_coeff = kc;
      model_step(rst, v, sof, pix, kv, kc);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ctl(input string tag, input bit pr, input bit kr, input bit en,
                          input bit win, input bit ld);
      check({tag, ".pix_ready"}, o_pix_ready, pr);
      check({tag, ".knl_ready"}, o_knl_ready, kr);
      check({tag, ".en_conv"},   o_en_conv,   en);
      check({tag, ".win_valid"}, o_win_valid, win);
      check({tag, ".load_knl"},  o_load_knl,  ld);
   endtask

   task automatic chk_dat(input string tag, input int d1, input int d2, input int d3);
      check({tag, ".data1"}, o_data1, pix_t'(d1));
      check({tag, ".data2"}, o_data2, pix_t'(d2));
      check({tag, ".data3"}, o_data3, pix_t'(d3));
   endtask

   task automatic check_model(input int i);
      string tag;
      tag = $sformatf("rnd%0d", i);
      chk_ctl(tag, e_pr, e_kr, e_en, e_win, e_ld);
      if (e_k1) check({tag, ".data1"}, o_data1, e_d1);
      if (e_k2) check({tag, ".data2"}, o_data2, e_d2);
      if (e_k3) check({tag, ".data3"}, o_data3, e_d3);
   endtask

   function automatic vec_t mk(bit v, bit sof, int pix, bit kv, int kc, bit pr, bit kr,
                               bit en, bit win, bit ld, bit c12, bit c3,
                               int d1, int d2, int d3);
      vec_t r;
      r.v = v; r.sof = sof; r.pix = pix_t'(pix); r.kv = kv; r.kc = pix_t'(kc);
      r.pr = pr; r.kr = kr; r.en = en; r.win = win; r.ld = ld;
      r.c12 = c12; r.c3 = c3;
      r.d1 = pix_t'(d1); r.d2 = pix_t'(d2); r.d3 = pix_t'(d3);
      return r;
   endfunction

   initial begin
      vec_t vecs[$];
      int   kseq[$];
      bit   rst, v, sof, kv;

      i_rst = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_pixel = '0;
      i_knl_valid = 1'b0; i_knl_coeff = '0;

      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      chk_ctl("reset", 1, 1, 0, 0, 0);
      chk_dat("reset", 0, 0, 0);

      // Kernel 1..9 with gaps (0 = gap); pixels driven while busy must be dropped
      kseq = '{1, 0, 2, 3, 4, 0, 5, 6, 7, 8, 0, 9};
      foreach (kseq[i]) begin
         if (kseq[i] == 9)
            vecs.push_back(mk(1, 0, 99, 1, 9, 0, 0, 0, 0, 1, 1, 1, 1, 4, 7));
         else
            vecs.push_back(mk(i != 0, 0, 99, kseq[i] != 0, kseq[i], 0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
      end
      vecs.push_back(mk(1, 0, 99, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 5, 8));
      vecs.push_back(mk(1, 0, 99, 0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 6, 9));
      vecs.push_back(mk(1, 0, 99, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 99, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0));
      // Fill and stream 0..15 from start of frame, through wrap and row saturation
      for (int p = 0; p < 16; p++)
         vecs.push_back(mk(1, p == 0, p, 0, 0, 1, 1, p >= 8, (p >= 8) && (p % W >= 2), 0,
                           p >= 8, 1, p - 8, p - 4, p));

      for (int i = 0; i < vecs.size(); i++) begin
         cycle(0, vecs[i].v, vecs[i].sof, vecs[i].pix, vecs[i].kv, vecs[i].kc);
         chk_ctl($sformatf("vec%0d", i), vecs[i].pr, vecs[i].kr, vecs[i].en, vecs[i].win, vecs[i].ld);
         if (vecs[i].c12) begin
            check($sformatf("vec%0d.data1", i), o_data1, vecs[i].d1);
            check($sformatf("vec%0d.data2", i), o_data2, vecs[i].d2);
         end
         if (vecs[i].c3) check($sformatf("vec%0d.data3", i), o_data3, vecs[i].d3);
      end

      // Pixel and coefficient in the same cycle, then dropped pixels during the load
      cycle(0, 1, 0, 16, 1, 10);
      chk_ctl("simul", 0, 1, 1, 0, 0);
      chk_dat("simul", 8, 12, 16);
      for (int k = 11; k <= 18; k++) begin
         cycle(0, 1, 0, 100 + k, 1, k);
         if (k < 18) begin
            chk_ctl("kcollect_drop", 0, 1, 0, 0, 0);
            chk_dat("kcollect_drop", 8, 12, 16);
         end else begin
            chk_ctl("ksend0", 0, 0, 0, 0, 1);
            chk_dat("ksend0", 10, 13, 16);
         end
      end
      cycle(0, 1, 0, 120, 0, 0);
      chk_ctl("ksend1", 0, 0, 0, 0, 1);
      chk_dat("ksend1", 11, 14, 17);
      cycle(0, 1, 0, 121, 0, 0);
      chk_ctl("ksend2", 0, 0, 0, 0, 1);
      chk_dat("ksend2", 12, 15, 18);
      cycle(0, 1, 0, 122, 0, 0);
      chk_ctl("ksend3", 0, 0, 0, 0, 1);
      chk_dat("ksend3", 0, 0, 0);
      cycle(0, 1, 0, 123, 0, 0);
      chk_ctl("ksend_done", 1, 1, 0, 0, 0);
      chk_dat("ksend_done", 0, 0, 0);
      // Stream resumes at col 1 without refill
      cycle(0, 1, 0, 17, 0, 0);
      chk_ctl("resume17", 1, 1, 1, 0, 0);
      chk_dat("resume17", 9, 13, 17);
      cycle(0, 1, 0, 18, 0, 0);
      chk_ctl("resume18", 1, 1, 1, 1, 0);
      chk_dat("resume18", 10, 14, 18);

      // i_sof mid-line at col 2 of a saturated row
      cycle(0, 1, 0, 19, 0, 0);
      chk_dat("p19", 11, 15, 19);
      cycle(0, 1, 0, 20, 0, 0);
      chk_dat("p20", 12, 16, 20);
      cycle(0, 1, 0, 21, 0, 0);
      chk_ctl("p21", 1, 1, 1, 0, 0);
      cycle(0, 1, 1, 30, 0, 0);
      chk_ctl("sof_mid", 1, 1, 0, 0, 0);
      chk_dat("sof_mid", 16, 20, 30);
      for (int p = 31; p <= 37; p++) begin
         cycle(0, 1, 0, p, 0, 0);
         check($sformatf("sof_refill%0d.en_conv", p), o_en_conv, 1'b0);
         if (p == 33) begin
            cycle(0, 0, 0, 0, 0, 0);
            check("sof_idle.en_conv", o_en_conv, 1'b0);
            check("sof_idle.data3", o_data3, pix_t'(33));
         end
      end
      cycle(0, 1, 0, 38, 0, 0);
      chk_ctl("sof_full", 1, 1, 1, 0, 0);
      chk_dat("sof_full", 30, 34, 38);

      // Reset in the middle of KSEND
      for (int k = 1; k <= 9; k++) cycle(0, 0, 0, 0, 1, k);
      chk_dat("ksend_pre_rst", 1, 4, 7);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      chk_ctl("rst_ksend", 1, 1, 0, 0, 0);
      chk_dat("rst_ksend", 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      chk_ctl("rst_ksend_after", 1, 1, 0, 0, 0);

      // Random traffic against the reference model
      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 399) == 0);
         v   = ($urandom_range(0, 3) != 0);
         sof = ($urandom_range(0, 29) == 0);
         kv  = (m_mode == M_COLLECT) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 59) == 0);
         cycle(rst, v, sof, pix_t'($urandom), kv, pix_t'($urandom));
         check_model(i);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
